serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Serial-in / parallel-out frame receiver: the receive end of the team's 10-bit serial frame link. Idle line high, one start bit (0), 8 data bits LSB first, one stop bit (1). Samples the serial line at mid-bit using a bit-rate-multiple strobe, assembles the byte, and presents it on an 8-bit port with a valid/ack handshake. Sits between the board-level serial input pin and the byte-consuming control logic.

## Interface
Parameters:
- SPB, 8, sr_clk ticks per bit period; even, 4..64.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- sr_clk  input  1  sample strobe, one clk cycle high, SPB ticks per bit.
- enable  input  1  receiver enable; low aborts any frame in progress.
- data_in  input  1  serial line, asynchronous to clk.
- ack  input  1  consumer acknowledge of data_out.
- data_out  output  8  last good received byte.
- valid  output  1  data_out holds an unacknowledged byte.
- busy  output  1  frame reception in progress (state != IDLE).
- framing_err  output  1  one-clk pulse: stop bit sampled 0.
- overrun_err  output  1  one-clk pulse: good frame arrived while valid high.

## Operation
- data_in passes a 2-flop synchronizer (reset value 1); all logic uses the synchronized line `rxs`.
- States: IDLE, START, DATA, STOP, BREAK. tick counter (log2 SPB bits), bit counter (3 bits), 8-bit shift register.
- IDLE: on sr_clk with rxs=0 and enable=1 -> START, tick counter cleared.
- START: count sr_clk ticks; at tick SPB/2-1 sample rxs: 0 -> DATA (tick counter cleared, bit counter 0); 1 -> IDLE (false start, no flags).
- DATA: every SPB ticks sample rxs, shift into MSB of shift register (so first bit ends in bit 0); after bit 7 -> STOP.
- STOP: after SPB ticks sample rxs. 1 and valid=0 (after ack in same cycle) -> data_out <= shift register, valid <= 1, -> IDLE. 1 and valid=1 -> overrun_err pulse, data_out and valid unchanged, -> IDLE. 0 -> framing_err pulse, data_out unchanged, -> BREAK.
- BREAK: stay until rxs=1 on an sr_clk tick, then -> IDLE. Prevents a held-low line from being read as repeated frames.
- valid clears on the clk edge where ack=1. Simultaneous ack and good-stop commit: ack clears old byte, new byte loads, valid stays 1, no overrun.
- enable=0: next clk edge forces IDLE, counters cleared; data_out/valid preserved; ack still honoured.
- Counters only advance on clk edges with sr_clk=1; sr_clk ignored while held high beyond one cycle only in the sense that each high clk cycle counts as one tick.

## Timing
- Reset values: data_out=8'h00, valid=0, busy=0, framing_err=0, overrun_err=0, rxs=1, state IDLE.
- Synchronizer latency: 2 clk.
- Start-to-commit: start edge to valid high = 2 clk + (SPB/2 + 9*SPB) sr_clk ticks, plus <=1 tick detection jitter.
- valid rises on the same edge data_out updates; error pulses last exactly one clk.
- busy high from IDLE->START edge until return to IDLE (includes BREAK).
- Reset asserted mid-frame: all outputs return to reset values immediately; no partial byte is ever committed.

## Configuration
- SERIAL_RX_PARITY_EN defined: frame is 11 bits; an even-parity bit follows bit 7, sampled in extra state PARITY; mismatch produces a one-clk parity_err output pulse, byte is not committed, FSM proceeds to STOP normally (stop-bit checks still apply). Port parity_err exists only when defined.
- Not defined: 10-bit frame, no PARITY state, no parity_err port.

## Test plan
- SPB=8, send 8'hA5 (line: 0,1,0,1,0,0,1,0,1,1) -> data_out=8'hA5, valid=1, no error pulses; ack -> valid=0 next edge.
- Send 8'h3C then 8'hC3 without ack -> data_out stays 8'h3C, overrun_err one pulse after second stop bit.
- Glitch: line low for 2 ticks then high -> no state beyond START, busy returns 0, valid stays 0.
- Send 8'hFF with stop bit 0, line held low 30 ticks -> framing_err one pulse, busy high through BREAK, no new frame until line high; data_out unchanged.
- Assert reset (low) after 4 data bits of 8'h55 -> all outputs reset values; next clean frame 8'h81 received correctly.
- With SERIAL_RX_PARITY_EN: 8'h07 with parity bit 0 -> parity_err pulse, valid stays 0; with parity bit 1 -> data_out=8'h07, valid=1.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receive end of the 10-bit serial frame link (start, 8 data
// LSB first, stop). Mid-bit sampling on an SPB-per-bit strobe, byte presented
// with a valid/ack handshake.
// Optional build macro: SERIAL_RX_PARITY_EN adds an even-parity bit after bit 7,
// a PARITY state and a parity_err pulse output.
module serial_frame_rx #(
   parameter int unsigned SPB = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sr_clk,
   input  logic       enable,
   input  logic       data_in,
   input  logic       ack,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       busy,
   output logic       framing_err,
   output logic       overrun_err
`ifdef SERIAL_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int unsigned TW = $clog2(SPB);
   localparam logic [TW-1:0] HALF_TICK = TW'(SPB / 2 - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(SPB - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
`ifdef SERIAL_RX_PARITY_EN
      ,
      S_PARITY
`endif
   } state_t;

   state_t          state_q, state_d;
   logic            rx_meta, rxs;
   logic [TW-1:0]   tick_q, tick_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_d;
   logic            valid_d, busy_d, ferr_d, oerr_d;
   logic            good_byte;

`ifdef SERIAL_RX_PARITY_EN
   logic            pbad_q, pbad_d, perr_d;
   assign good_byte = !pbad_q;
`else
   assign good_byte = 1'b1;
`endif

   // Two-flop synchronizer for the asynchronous serial line (idles high)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= data_in;
         rxs     <= rx_meta;
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         data_out    <= 8'h00;
         valid       <= 1'b0;
         busy        <= 1'b0;
         framing_err <= 1'b0;
         overrun_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         pbad_q      <= 1'b0;
         parity_err  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         data_out    <= data_d;
         valid       <= valid_d;
         busy        <= busy_d;
         framing_err <= ferr_d;
         overrun_err <= oerr_d;
`ifdef SERIAL_RX_PARITY_EN
         pbad_q      <= pbad_d;
         parity_err  <= perr_d;
`endif
      end
   end

   // Next-state and output logic; counters only move on strobe cycles
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_out;
      valid_d = valid & ~ack;
      ferr_d  = 1'b0;
      oerr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      pbad_d  = pbad_q;
      perr_d  = 1'b0;
`endif
      if (!enable) begin
         state_d = S_IDLE;
         tick_d  = '0;
         bit_d   = '0;
      end else if (sr_clk) begin
         case (state_q)
            S_IDLE: begin
               if (!rxs) begin
                  state_d = S_START;
                  tick_d  = '0;
`ifdef SERIAL_RX_PARITY_EN
                  pbad_d  = 1'b0;
`endif
               end
            end
            S_START: begin
               if (tick_q == HALF_TICK) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = rxs ? S_IDLE : S_DATA;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            S_DATA: begin
               if (tick_q == LAST_TICK) begin
                  tick_d  = '0;
                  shift_d = {rxs, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
               if (tick_q == LAST_TICK) begin
                  tick_d  = '0;
                  state_d = S_STOP;
                  if (rxs != ^shift_q) begin
                     pbad_d = 1'b1;
                     perr_d = 1'b1;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
`endif
            S_STOP: begin
               if (tick_q == LAST_TICK) begin
                  tick_d = '0;
                  if (rxs) begin
                     state_d = S_IDLE;
                     if (good_byte) begin
                        if (valid_d) begin
                           oerr_d = 1'b1;
                        end else begin
                           data_d  = shift_q;
                           valid_d = 1'b1;
                        end
                     end
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = S_BREAK;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            S_BREAK: begin
               if (rxs) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               tick_d  = '0;
               bit_d   = '0;
            end
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: table of frames plus hand sequences for glitch,
// break, enable abort and mid-frame reset; events checked against a queue.
module tb_serial_frame_rx;

   localparam int unsigned SPB          = 8;
   localparam int          CLK_PER_TICK = 4;

   typedef enum logic [1:0] {EV_COMMIT, EV_FERR, EV_OERR, EV_PERR} ev_kind_t;

   typedef struct {
      ev_kind_t   kind;
      logic [7:0] data;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       do_ack;
      ev_kind_t   kind;
      logic [7:0] exp_data;
      logic       exp_valid;
   } vec_t;

   logic       clk, reset, sr_clk, enable, data_in, ack;
   logic [7:0] data_out;
   logic       valid, busy, framing_err, overrun_err;
`ifdef SERIAL_RX_PARITY_EN
   logic       parity_err;
   logic       par_flip;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   int   tick_div;
   ev_t  exp_q[$];
   vec_t vecs[6];
   logic v_prev, f_prev, o_prev;

   serial_frame_rx #(.SPB(SPB)) dut (
      .clk         (clk),
      .reset       (reset),
      .sr_clk      (sr_clk),
      .enable      (enable),
      .data_in     (data_in),
      .ack         (ack),
      .data_out    (data_out),
      .valid       (valid),
      .busy        (busy),
      .framing_err (framing_err),
      .overrun_err (overrun_err)
`ifdef SERIAL_RX_PARITY_EN
      ,
      .parity_err  (parity_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One-cycle strobe every CLK_PER_TICK clocks, changed on the falling edge
   initial begin
      sr_clk   = 1'b0;
      tick_div = 0;
      forever begin
         @(negedge clk);
         tick_div = (tick_div == CLK_PER_TICK - 1) ? 0 : tick_div + 1;
         sr_clk   = (tick_div == 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic observe(input ev_kind_t kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
      end else begin
         e = exp_q.pop_front();
         check8("event_kind", 8'(kind), 8'(e.kind));
         check8("event_data_out", data_out, e.data);
      end
   endtask

   task automatic expect_ev(input ev_kind_t kind, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Event monitor sampled on the falling edge
   initial begin
      v_prev = 1'b0;
      f_prev = 1'b0;
      o_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (f_prev) check8("framing_err_width", {7'd0, framing_err}, 8'd0);
         if (o_prev) check8("overrun_err_width", {7'd0, overrun_err}, 8'd0);
         if (valid && !v_prev) observe(EV_COMMIT);
         if (framing_err) observe(EV_FERR);
         if (overrun_err) observe(EV_OERR);
`ifdef SERIAL_RX_PARITY_EN
         if (parity_err) observe(EV_PERR);
`endif
         v_prev = valid;
         f_prev = framing_err;
         o_prev = overrun_err;
      end
   end

   // Wait n strobe ticks as seen by the DUT, then return on a falling edge
   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!sr_clk) @(posedge clk);
      end
      @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      data_in = b;
      wait_ticks(SPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
      send_bit((^d) ^ par_flip);
`endif
      send_bit(stop);
   endtask

   task automatic send_partial(input logic [7:0] d, input int nbits);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(d[i]);
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check8("valid_after_ack", {7'd0, valid}, 8'd0);
   endtask

   initial begin
      reset   = 1'b0;
      enable  = 1'b1;
      data_in = 1'b1;
      ack     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_flip = 1'b0;
`endif
      //         data   stop  ack   event      data_out valid
      vecs[0] = '{8'hA5, 1'b1, 1'b1, EV_COMMIT, 8'hA5,   1'b1};
      vecs[1] = '{8'h3C, 1'b1, 1'b0, EV_COMMIT, 8'h3C,   1'b1};
      vecs[2] = '{8'hC3, 1'b1, 1'b1, EV_OERR,   8'h3C,   1'b1};
      vecs[3] = '{8'h81, 1'b1, 1'b1, EV_COMMIT, 8'h81,   1'b1};
      vecs[4] = '{8'h00, 1'b1, 1'b0, EV_COMMIT, 8'h00,   1'b1};
      vecs[5] = '{8'h7E, 1'b1, 1'b1, EV_OERR,   8'h00,   1'b1};

      repeat (3) @(negedge clk);
      check8("rst_data_out", data_out, 8'h00);
      check8("rst_valid", {7'd0, valid}, 8'd0);
      check8("rst_busy", {7'd0, busy}, 8'd0);
      check8("rst_framing_err", {7'd0, framing_err}, 8'd0);
      check8("rst_overrun_err", {7'd0, overrun_err}, 8'd0);
      reset = 1'b1;
      wait_ticks(4);

      // Table of whole frames
      for (int v = 0; v < 6; v++) begin
         expect_ev(vecs[v].kind, vecs[v].exp_data);
         send_frame(vecs[v].data, vecs[v].stop);
         data_in = 1'b1;
         wait_ticks(SPB);
         check8("vec_data_out", data_out, vecs[v].exp_data);
         check8("vec_valid", {7'd0, valid}, {7'd0, vecs[v].exp_valid});
         check8("vec_busy", {7'd0, busy}, 8'd0);
         if (vecs[v].do_ack) pulse_ack();
      end

      // Glitch: two ticks low is a false start
      data_in = 1'b0;
      wait_ticks(2);
      check8("glitch_busy_high", {7'd0, busy}, 8'd1);
      data_in = 1'b1;
      wait_ticks(6);
      check8("glitch_busy_low", {7'd0, busy}, 8'd0);
      check8("glitch_valid", {7'd0, valid}, 8'd0);

      // Bad stop bit, line held low: one framing error, stay in break
      expect_ev(EV_FERR, 8'h00);
      send_frame(8'hFF, 1'b0);
      wait_ticks(22);
      check8("break_busy", {7'd0, busy}, 8'd1);
      check8("break_data_out", data_out, 8'h00);
      check8("break_valid", {7'd0, valid}, 8'd0);
      data_in = 1'b1;
      wait_ticks(3);
      check8("break_exit_busy", {7'd0, busy}, 8'd0);
      wait_ticks(SPB);

      // Enable dropped mid-frame aborts without commit
      send_partial(8'h96, 3);
      enable = 1'b0;
      @(negedge clk);
      check8("disable_busy", {7'd0, busy}, 8'd0);
      data_in = 1'b1;
      wait_ticks(2);
      enable = 1'b1;
      wait_ticks(SPB * 8);
      check8("disable_valid", {7'd0, valid}, 8'd0);

      // Reset mid-frame with a byte pending, then a clean frame
      expect_ev(EV_COMMIT, 8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_ticks(SPB);
      check8("pre_reset_data_out", data_out, 8'h5A);
      send_partial(8'h55, 4);
      reset = 1'b0;
      #1;
      check8("midrst_data_out", data_out, 8'h00);
      check8("midrst_valid", {7'd0, valid}, 8'd0);
      check8("midrst_busy", {7'd0, busy}, 8'd0);
      data_in = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      wait_ticks(SPB * 2);
      check8("post_rst_busy", {7'd0, busy}, 8'd0);
      expect_ev(EV_COMMIT, 8'h81);
      send_frame(8'h81, 1'b1);
      wait_ticks(SPB);
      check8("post_rst_data_out", data_out, 8'h81);
      check8("post_rst_valid", {7'd0, valid}, 8'd1);
      pulse_ack();

`ifdef SERIAL_RX_PARITY_EN
      // Wrong parity: error pulse, nothing committed
      par_flip = 1'b1;
      expect_ev(EV_PERR, 8'h81);
      send_frame(8'h07, 1'b1);
      wait_ticks(SPB);
      check8("par_bad_valid", {7'd0, valid}, 8'd0);
      check8("par_bad_data_out", data_out, 8'h81);
      par_flip = 1'b0;
      expect_ev(EV_COMMIT, 8'h07);
      send_frame(8'h07, 1'b1);
      wait_ticks(SPB);
      check8("par_ok_data_out", data_out, 8'h07);
      check8("par_ok_valid", {7'd0, valid}, 8'd1);
`endif

      wait_ticks(2);
      check8("events_outstanding", 8'(exp_q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
